// File: rtl/bcd_time_counter_12h.sv
// bcd_time_counter_12h
//   12-hour BCD time-of-day counter (HH:MM:SS). It advances once per second,
//   and its hours run 12, 01 .. 11, 12. A set mode adjusts hours and minutes
//   from a debounced increment button.
//
// Parameters:
//   CLK_DIV     clk cycles per second (1 .. 2**24); 1 = every edge is a second
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset, restores 12:00:00
//   set_mode    1 = set mode (counting frozen, seconds held at 00), 0 = run
//   set_sel     field adjusted in set mode: 0 = minutes, 1 = hours
//   set_inc     debounced increment request, rising-edge detected here
//   sec_tens / sec_units / min_tens / min_units / hour_tens / hour_units
//               BCD time digits
//   min_carry   high in the tick cycle showing xx:59:59 (pre-increment hours)
//   sec_tick    one-second strobe, one clk cycle wide
//
// Optional build macro CLOCK_SET_BLINK_EN adds blink_min / blink_hour:
//   in set mode the selected field's bit toggles every clk, otherwise 0.

module bcd_time_counter_12h #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       set_sel,
  input  logic       set_inc,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic       min_carry,
  output logic       sec_tick
`ifdef CLOCK_SET_BLINK_EN
  ,
  output logic       blink_min,
  output logic       blink_hour
`endif
);

  // CLK_DIV = 1 still needs a one-bit counter that simply stays at 0.
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          set_inc_d;
  logic          inc_rise;
  logic          sec_wrap;
  logic          min_wrap;
  logic [3:0]    min_tens_nx;
  logic [3:0]    min_units_nx;
  logic [3:0]    hour_tens_nx;
  logic [3:0]    hour_units_nx;

  // Gated by rst_n so the strobe stays low while reset is held, even with CLK_DIV = 1.
  assign sec_tick  = rst_n && !set_mode && (div_cnt == DIV_MAX);
  assign inc_rise  = set_inc && !set_inc_d;
  assign sec_wrap  = (sec_tens == 4'd5) && (sec_units == 4'd9);
  assign min_wrap  = (min_tens == 4'd5) && (min_units == 4'd9);
  assign min_carry = sec_tick && sec_wrap && min_wrap;

  // Prescaler; held at 0 in set mode so the first second after exit takes a full CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (set_mode || (div_cnt == DIV_MAX)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_inc_d <= 1'b0;
    end else begin
      set_inc_d <= set_inc;
    end
  end

  // Successor values for minutes (00..59) and hours (12, 01 .. 11), shared by run and set mode.
  always_comb begin
    min_tens_nx  = min_tens;
    min_units_nx = min_units + 4'd1;
    if (min_units == 4'd9) begin
      min_units_nx = 4'd0;
      min_tens_nx  = (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
    end
  end

  always_comb begin
    hour_tens_nx  = hour_tens;
    hour_units_nx = hour_units + 4'd1;
    if ((hour_tens == 4'd1) && (hour_units == 4'd2)) begin
      hour_tens_nx  = 4'd0;
      hour_units_nx = 4'd1;
    end else if (hour_units == 4'd9) begin
      hour_tens_nx  = 4'd1;
      hour_units_nx = 4'd0;
    end
  end

  // Time registers. Set-mode minute increments wrap 59 -> 00 without touching hours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tens   <= 4'd0;
      sec_units  <= 4'd0;
      min_tens   <= 4'd0;
      min_units  <= 4'd0;
      hour_tens  <= 4'd1;
      hour_units <= 4'd2;
    end else if (set_mode) begin
      sec_tens  <= 4'd0;
      sec_units <= 4'd0;
      if (inc_rise) begin
        if (set_sel) begin
          hour_tens  <= hour_tens_nx;
          hour_units <= hour_units_nx;
        end else begin
          min_tens  <= min_tens_nx;
          min_units <= min_units_nx;
        end
      end
    end else if (sec_tick) begin
      if (sec_units == 4'd9) begin
        sec_units <= 4'd0;
        sec_tens  <= sec_wrap ? 4'd0 : sec_tens + 4'd1;
        if (sec_wrap) begin
          min_tens  <= min_tens_nx;
          min_units <= min_units_nx;
          if (min_wrap) begin
            hour_tens  <= hour_tens_nx;
            hour_units <= hour_units_nx;
          end
        end
      end else begin
        sec_units <= sec_units + 4'd1;
      end
    end
  end

`ifdef CLOCK_SET_BLINK_EN
  // Only the selected field blinks; the other is forced visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_min  <= 1'b0;
      blink_hour <= 1'b0;
    end else if (set_mode) begin
      blink_min  <= !set_sel && !blink_min;
      blink_hour <= set_sel && !blink_hour;
    end else begin
      blink_min  <= 1'b0;
      blink_hour <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_time_counter_12h.sv
// tb_bcd_time_counter_12h
//   Two instances (CLK_DIV = 1 and CLK_DIV = 4) share one stimulus stream.
//   The reference model keeps time as seconds since 12:00:00 (0 .. 43199)
//   and derives the BCD digits arithmetically. Expected outputs are queued
//   by the driver and compared at each negedge by an independent monitor.

module tb_bcd_time_counter_12h;

  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;

  typedef struct packed {
    logic [47:0] digits;
    logic [1:0]  carry;
    logic [1:0]  tick;
    logic [1:0]  bmin;
    logic [1:0]  bhour;
  } exp_t;

  logic clk;
  logic rst_n;
  logic set_mode;
  logic set_sel;
  logic set_inc;

  logic [3:0] st0, su0, mt0, mu0, ht0, hu0;
  logic [3:0] st1, su1, mt1, mu1, ht1, hu1;
  logic       carry0, carry1, tick0, tick1;
  logic       bm0, bh0, bm1, bh1;
  logic [23:0] dig0, dig1;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  int   tSec[2];
  int   phase[2];
  int   divs[2];
  bit   bMin[2];
  bit   bHour[2];
  bit   incD;

  bcd_time_counter_12h #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_mode(set_mode), .set_sel(set_sel), .set_inc(set_inc),
    .sec_tens(st0), .sec_units(su0), .min_tens(mt0), .min_units(mu0),
    .hour_tens(ht0), .hour_units(hu0), .min_carry(carry0), .sec_tick(tick0)
`ifdef CLOCK_SET_BLINK_EN
    , .blink_min(bm0), .blink_hour(bh0)
`endif
  );

  bcd_time_counter_12h #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_mode(set_mode), .set_sel(set_sel), .set_inc(set_inc),
    .sec_tens(st1), .sec_units(su1), .min_tens(mt1), .min_units(mu1),
    .hour_tens(ht1), .hour_units(hu1), .min_carry(carry1), .sec_tick(tick1)
`ifdef CLOCK_SET_BLINK_EN
    , .blink_min(bm1), .blink_hour(bh1)
`endif
  );

`ifndef CLOCK_SET_BLINK_EN
  assign bm0 = 1'b0;
  assign bh0 = 1'b0;
  assign bm1 = 1'b0;
  assign bh1 = 1'b0;
`endif

  assign dig0 = {ht0, hu0, mt0, mu0, st0, su0};
  assign dig1 = {ht1, hu1, mt1, mu1, st1, su1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Time as HH:MM:SS BCD from seconds since 12:00:00.
  function automatic logic [23:0] digitsOf(input int t);
    int h, hd, m, s;
    h  = t / 3600;
    hd = (h == 0) ? 12 : h;
    m  = (t / 60) % 60;
    s  = t % 60;
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s dut%0d t=%0t got %h expected %h", name, k, $time, got, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      tSec[k]  = 0;
      phase[k] = 0;
      bMin[k]  = 1'b0;
      bHour[k] = 1'b0;
    end
    incD = 1'b0;
  endtask

  // Effect of one clock edge given the inputs that were present at that edge.
  task automatic modelEdge();
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (set_mode) begin
          tSec[k]  = tSec[k] - (tSec[k] % 60);
          phase[k] = 0;
          if (set_inc && !incD) begin
            if (set_sel) tSec[k] = (((tSec[k] / 3600) + 1) % 12) * 3600 + (tSec[k] % 3600);
            else         tSec[k] = (tSec[k] / 3600) * 3600 + ((((tSec[k] / 60) % 60) + 1) % 60) * 60;
          end
          bMin[k]  = !set_sel ? !bMin[k] : 1'b0;
          bHour[k] = set_sel ? !bHour[k] : 1'b0;
        end else begin
          bMin[k]  = 1'b0;
          bHour[k] = 1'b0;
          if (phase[k] == divs[k] - 1) begin
            tSec[k]  = (tSec[k] + 1) % 43200;
            phase[k] = 0;
          end else begin
            phase[k]++;
          end
        end
      end
      incD = set_inc;
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    bit   tk;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      tk = rst_n && !set_mode && (phase[k] == divs[k] - 1);
      e.digits[k*24 +: 24] = digitsOf(tSec[k]);
      e.tick[k]  = tk;
      e.carry[k] = tk && ((tSec[k] % 3600) == 3599);
      e.bmin[k]  = bMin[k];
      e.bhour[k] = bHour[k];
    end
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input bit sm, input bit sel, input bit inc, input bit rstn);
    @(posedge clk);
    #2;
    modelEdge();
    set_mode = sm;
    set_sel  = sel;
    set_inc  = inc;
    rst_n    = rstn;
    if (!rstn) modelReset();
    pushExpected();
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pressInc(input bit sel);
    applyStimulus(1'b1, sel, 1'b1, 1'b1);
    applyStimulus(1'b1, sel, 1'b0, 1'b1);
  endtask

  // Enter set mode and step the 1 Hz instance to the target hour and minute.
  task automatic setTime(input int h, input int m);
    int nh, nm;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    nh = ((h % 12) - (tSec[0] / 3600) + 12) % 12;
    nm = (m - ((tSec[0] / 60) % 60) + 60) % 60;
    for (int i = 0; i < nh; i++) pressInc(1'b1);
    for (int i = 0; i < nm; i++) pressInc(1'b0);
  endtask

  // Reset asserted between edges must clear the outputs before any edge arrives.
  task automatic asyncReset();
    @(posedge clk);
    #2;
    modelEdge();
    rst_n = 1'b0;
    modelReset();
    pushExpected();
    #1;
    checkOutput("async_rst_time", 0, {8'h0, dig0}, 32'h0012_0000);
    checkOutput("async_rst_time", 1, {8'h0, dig1}, 32'h0012_0000);
    checkOutput("async_rst_carry", 0, {31'h0, carry0}, 32'h0);
    checkOutput("async_rst_tick", 0, {31'h0, tick0}, 32'h0);
`ifdef CLOCK_SET_BLINK_EN
    checkOutput("async_rst_blink", 0, {30'h0, bm0, bh0}, 32'h0);
    checkOutput("async_rst_blink", 1, {30'h0, bm1, bh1}, 32'h0);
`endif
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("time", 0, {8'h0, dig0}, {8'h0, e.digits[23:0]});
        checkOutput("time", 1, {8'h0, dig1}, {8'h0, e.digits[47:24]});
        checkOutput("min_carry", 0, {31'h0, carry0}, {31'h0, e.carry[0]});
        checkOutput("min_carry", 1, {31'h0, carry1}, {31'h0, e.carry[1]});
        checkOutput("sec_tick", 0, {31'h0, tick0}, {31'h0, e.tick[0]});
        checkOutput("sec_tick", 1, {31'h0, tick1}, {31'h0, e.tick[1]});
`ifdef CLOCK_SET_BLINK_EN
        checkOutput("blink", 0, {30'h0, bm0, bh0}, {30'h0, e.bmin[0], e.bhour[0]});
        checkOutput("blink", 1, {30'h0, bm1, bh1}, {30'h0, e.bmin[1], e.bhour[1]});
`endif
      end
    end
  end

  initial begin
    bit sm;
    divs[0]  = DIV0;
    divs[1]  = DIV1;
    rst_n    = 1'b0;
    set_mode = 1'b0;
    set_sel  = 1'b0;
    set_inc  = 1'b0;
    modelReset();

    $display("[TB] reset hold and release");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(3);

    $display("[TB] 12:59:59 rollover to 01:00:00");
    setTime(12, 59);
    runTicks(62);

    $display("[TB] 09:59:59 -> 10:00:00 and 11:59:59 -> 12:00:00");
    setTime(9, 59);
    runTicks(61);
    setTime(11, 59);
    runTicks(61);

    $display("[TB] set-mode minute wrap and held increment");
    setTime(12, 59);
    pressInc(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

    $display("[TB] set-mode exit timing");
    runTicks(12);

    $display("[TB] async reset at 07:23:41");
    setTime(7, 23);
    runTicks(41);
    asyncReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(3);

    $display("[TB] randomized operation");
    sm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) sm = !sm;
      applyStimulus(sm, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 199) != 0));
    end
    runTicks(2);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", 0, 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
